// File: rtl/booth4_ctrl.sv
// Sequencer for the radix-4 Booth multiplier datapath: drives the c0..c6 strobes and decodes {Q[1],Q[0],Q[-1]}.
// Optional feature macro BOOTH_CYCLE_CNT_EN adds the cyc_cnt per-operation cycle counter output.
module booth4_ctrl #(
    parameter int unsigned N     = 8,
    parameter int unsigned CNT_W = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [2:0] q_bits,
    output logic       c0,
    output logic       c2,
    output logic       c3,
    output logic       c4,
    output logic       c5,
    output logic       c6,
    output logic       busy,
    output logic       done
`ifdef BOOTH_CYCLE_CNT_EN
    ,
    output logic [7:0] cyc_cnt
`endif
);

    localparam int unsigned ITER = N / 2;
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(ITER - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        INIT   = 3'd1,
        DECODE = 3'd2,
        ADD    = 3'd3,
        SHIFT  = 3'd4,
        DONE   = 3'd5
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] iter_q;
    logic [CNT_W-1:0] iter_d;
    logic             sel2m_d;
    logic             sub_d;

`ifdef BOOTH_CYCLE_CNT_EN
    logic [7:0] cyc_d;
`endif

    // Next-state, iteration counter and Booth triplet decode
    always_comb begin
        state_d = state_q;
        iter_d  = iter_q;
        sel2m_d = 1'b0;
        sub_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) state_d = INIT;
            end
            INIT: begin
                iter_d  = '0;
                state_d = DECODE;
            end
            DECODE: begin
                unique case (q_bits)
                    3'b001, 3'b010: begin
                        state_d = ADD;
                    end
                    3'b011: begin
                        state_d = ADD;
                        sel2m_d = 1'b1;
                    end
                    3'b100: begin
                        state_d = ADD;
                        sel2m_d = 1'b1;
                        sub_d   = 1'b1;
                    end
                    3'b101, 3'b110: begin
                        state_d = ADD;
                        sub_d   = 1'b1;
                    end
                    default: begin
                        state_d = SHIFT;
                    end
                endcase
            end
            ADD: begin
                state_d = SHIFT;
            end
            SHIFT: begin
                iter_d  = iter_q + CNT_W'(1);
                state_d = (iter_q == LAST_ITER) ? DONE : DECODE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

`ifdef BOOTH_CYCLE_CNT_EN
    // Counts INIT..DONE cycles, saturating; holds through IDLE
    always_comb begin
        cyc_d = cyc_cnt;
        if (state_d == INIT) begin
            cyc_d = 8'd1;
        end else if ((state_d != IDLE) && (cyc_cnt != 8'hFF)) begin
            cyc_d = cyc_cnt + 8'd1;
        end
    end
`endif

    // Strobes are registered decodes of the next state, so they line up with the state they belong to
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            iter_q  <= '0;
            c0      <= 1'b0;
            c2      <= 1'b0;
            c3      <= 1'b0;
            c4      <= 1'b0;
            c5      <= 1'b0;
            c6      <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
`ifdef BOOTH_CYCLE_CNT_EN
            cyc_cnt <= 8'd0;
`endif
        end else begin
            state_q <= state_d;
            iter_q  <= iter_d;
            c0      <= (state_d == INIT);
            c2      <= (state_d == ADD);
            c3      <= (state_d == ADD) && sel2m_d;
            c4      <= (state_d == ADD) && sub_d;
            c5      <= (state_d == SHIFT);
            c6      <= (state_d == DONE);
            busy    <= (state_d != IDLE);
            done    <= (state_d == DONE);
`ifdef BOOTH_CYCLE_CNT_EN
            cyc_cnt <= cyc_d;
`endif
        end
    end

endmodule
